// File: rtl/spi_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_ctrl_if
//  Brief    : Toggle-handshake bundle between the SPI frame controller and
//             the core clock domain (request fields out, response in).
//  Revision : 1.0  initial release
// ============================================================================
interface spi_frame_ctrl_if;

    logic        req_tgl;
    logic [1:0]  cmd;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        rsp_tgl;
    logic [31:0] rdata;

    // master: SPI-side controller issuing requests
    modport master (
        output req_tgl,
        output cmd,
        output adr,
        output wdata,
        input  rsp_tgl,
        input  rdata
    );

    // slave: core-domain responder
    modport slave (
        input  req_tgl,
        input  cmd,
        input  adr,
        input  wdata,
        output rsp_tgl,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_ctrl
//  Brief    : SPI-clocked frame controller: receives 72-bit command frames,
//             hands them to the core via toggle handshake, returns read data.
//  Revision : 1.0  initial release
// ============================================================================
module spi_frame_ctrl #(
    parameter int FRAME_BITS  = 72,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic        sclk,
    input  wire logic        rstn,
    input  wire logic        cs,
    input  wire logic        mosi,
    output logic             miso,
    output logic             busy,
    output logic [7:0]       err_cnt,
    spi_frame_ctrl_if.master bus
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_SHIFT    = 3'd1;
    localparam logic [2:0] c_DECODE   = 3'd2;
    localparam logic [2:0] c_WAIT_RSP = 3'd3;
    localparam logic [2:0] c_ARM_TX   = 3'd4;
    localparam logic [2:0] c_SEND     = 3'd5;

    localparam logic [6:0] c_LAST_BIT = 7'(FRAME_BITS - 1);
    localparam int         c_OP_LSB   = FRAME_BITS - 8;
    localparam logic [1:0] c_CMD_RD   = 2'b10;
    localparam logic [7:0] c_RD_TAG   = 8'h0F;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [FRAME_BITS-1:0] r_sr;
    logic [6:0]            r_bitcnt;
    logic                  r_armed;
    logic                  r_req_tgl;
    logic [1:0]            r_cmd;
    logic [31:0]           r_adr;
    logic [31:0]           r_wdata;
    logic [7:0]            r_err_cnt;
    logic [SYNC_STAGES-1:0] r_rsp_sync;
    logic                  r_rsp_edge;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [2:0]            w_state_nxt;
    logic [FRAME_BITS-1:0] w_sr_nxt;
    logic [6:0]            w_bitcnt_nxt;
    logic                  w_req_nxt;
    logic [1:0]            w_cmd_nxt;
    logic [31:0]           w_adr_nxt;
    logic [31:0]           w_wdata_nxt;
    logic                  w_err_inc;
    logic                  w_frame_start;
    logic                  w_armed_nxt;
    logic [7:0]            w_err_nxt;

    logic [SYNC_STAGES:0]  w_sync_d;
    logic                  w_rsp_evt;
    logic [7:0]            w_opcode;
    logic                  w_op_valid;

    // Synchronizer chain: index 0 is the flop nearest rsp_tgl
    assign w_sync_d  = {r_rsp_sync, bus.rsp_tgl};
    assign w_rsp_evt = r_rsp_sync[SYNC_STAGES-1] ^ r_rsp_edge;

    assign w_opcode   = r_sr[FRAME_BITS-1 -: 8];
    assign w_op_valid = (w_opcode == 8'h01) || (w_opcode == 8'h02) ||
                        (w_opcode == 8'h03);

    // Any sampled cs=1 re-arms; starting a frame (rx or tx) disarms
    assign w_armed_nxt = cs ? 1'b1 : (w_frame_start ? 1'b0 : r_armed);
    assign w_err_nxt   = (w_err_inc && (r_err_cnt != 8'hFF)) ?
                         (r_err_cnt + 8'd1) : r_err_cnt;

    // ------------------------------------------------------------------
    // State and datapath register
    // ------------------------------------------------------------------
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_IDLE;
            r_sr       <= '0;
            r_bitcnt   <= 7'd0;
            r_armed    <= 1'b0;
            r_req_tgl  <= 1'b0;
            r_cmd      <= 2'b00;
            r_adr      <= 32'd0;
            r_wdata    <= 32'd0;
            r_err_cnt  <= 8'd0;
            r_rsp_sync <= '0;
            r_rsp_edge <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_sr_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_armed    <= w_armed_nxt;
            r_req_tgl  <= w_req_nxt;
            r_cmd      <= w_cmd_nxt;
            r_adr      <= w_adr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_err_cnt  <= w_err_nxt;
            r_rsp_sync <= w_sync_d[SYNC_STAGES-1:0];
            // Edge flop tracks every cycle, so stray events are consumed
            r_rsp_edge <= r_rsp_sync[SYNC_STAGES-1];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_sr_nxt      = r_sr;
        w_bitcnt_nxt  = r_bitcnt;
        w_req_nxt     = r_req_tgl;
        w_cmd_nxt     = r_cmd;
        w_adr_nxt     = r_adr;
        w_wdata_nxt   = r_wdata;
        w_err_inc     = 1'b0;
        w_frame_start = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (!cs && r_armed) begin
                    w_frame_start = 1'b1;
                    w_sr_nxt      = {r_sr[FRAME_BITS-2:0], mosi};
                    w_bitcnt_nxt  = 7'd1;
                    w_state_nxt   = c_SHIFT;
                end
            end

            c_SHIFT: begin
                if (cs) begin
                    w_err_inc    = 1'b1;
                    w_sr_nxt     = '0;
                    w_bitcnt_nxt = 7'd0;
                    w_state_nxt  = c_IDLE;
                end else begin
                    w_sr_nxt     = {r_sr[FRAME_BITS-2:0], mosi};
                    w_bitcnt_nxt = r_bitcnt + 7'd1;
                    if (r_bitcnt == c_LAST_BIT) begin
                        w_state_nxt = c_DECODE;
                    end
                end
            end

            c_DECODE: begin
                w_bitcnt_nxt = 7'd0;
                if (w_op_valid) begin
                    w_cmd_nxt   = r_sr[c_OP_LSB +: 2];
                    w_adr_nxt   = r_sr[c_OP_LSB-1 -: 32];
                    w_wdata_nxt = r_sr[31:0];
                    w_req_nxt   = ~r_req_tgl;
                    w_state_nxt = c_WAIT_RSP;
                end else begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end

            c_WAIT_RSP: begin
                if (w_rsp_evt) begin
                    if (r_cmd == c_CMD_RD) begin
                        w_sr_nxt    = {c_RD_TAG, r_adr, bus.rdata};
                        w_state_nxt = c_ARM_TX;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
            end

            c_ARM_TX: begin
                // Response frame only starts after a fresh cs high/low cycle
                if (r_armed && !cs) begin
                    w_frame_start = 1'b1;
                    w_bitcnt_nxt  = 7'd0;
                    w_state_nxt   = c_SEND;
                end
            end

            c_SEND: begin
                if (cs) begin
                    w_err_inc    = 1'b1;
                    w_sr_nxt     = '0;
                    w_bitcnt_nxt = 7'd0;
                    w_state_nxt  = c_IDLE;
                end else begin
                    w_sr_nxt     = {r_sr[FRAME_BITS-2:0], 1'b0};
                    w_bitcnt_nxt = r_bitcnt + 7'd1;
                    if (r_bitcnt == c_LAST_BIT) begin
                        w_state_nxt = c_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt  = c_IDLE;
                w_bitcnt_nxt = 7'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state != c_IDLE);
        miso = 1'b0;
        if (r_state == c_SEND) begin
            miso = r_sr[FRAME_BITS-1];
        end
    end

    assign err_cnt     = r_err_cnt;
    assign bus.req_tgl = r_req_tgl;
    assign bus.cmd     = r_cmd;
    assign bus.adr     = r_adr;
    assign bus.wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_frame_ctrl
//  Brief    : Self-checking bench: random frame transactions against a
//             transaction-level model of the frame controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_frame_ctrl;

    logic       sclk = 1'b0;
    logic       rstn = 1'b0;
    logic       cs   = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic       busy;
    logic [7:0] err_cnt;

    spi_frame_ctrl_if bus ();

    spi_frame_ctrl #(
        .FRAME_BITS  (72),
        .SYNC_STAGES (2)
    ) dut (
        .sclk    (sclk),
        .rstn    (rstn),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso),
        .busy    (busy),
        .err_cnt (err_cnt),
        .bus     (bus.master)
    );

    always #5 sclk = ~sclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model of the visible state
    logic        m_req;
    logic [1:0]  m_cmd;
    logic [31:0] m_adr;
    logic [31:0] m_wdata;
    int          m_err;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic bump_err();
        m_err = (m_err < 255) ? m_err + 1 : 255;
    endtask

    task automatic model_reset();
        m_req = 1'b0; m_cmd = 2'b00; m_adr = 32'd0; m_wdata = 32'd0; m_err = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_req"},   72'(bus.req_tgl), 72'(m_req));
        check({tag, "_cmd"},   72'(bus.cmd),     72'(m_cmd));
        check({tag, "_adr"},   72'(bus.adr),     72'(m_adr));
        check({tag, "_wdata"}, 72'(bus.wdata),   72'(m_wdata));
        check({tag, "_err"},   72'(err_cnt),     72'(m_err[7:0]));
    endtask

    task automatic arm();
        cs   = 1'b1;
        mosi = 1'($urandom);
        step(int'($urandom_range(1, 3)));
    endtask

    // Drive the first nbits of frame MSB first with cs low
    task automatic drive_bits(input logic [71:0] frame, input int nbits);
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = frame[71-i];
            step(1);
        end
    endtask

    // Legal command frame up to the point the request is issued
    task automatic issue_cmd(input string tag, input logic [7:0] op,
                             input logic [31:0] adr, input logic [31:0] wd);
        arm();
        drive_bits({op, adr, wd}, 72);
        cs = 1'b1;
        step(1);
        m_req   = ~m_req;
        m_cmd   = op[1:0];
        m_adr   = adr;
        m_wdata = wd;
        check_regs(tag);
        check({tag, "_busy"}, 72'(busy), 72'(1'b1));
    endtask

    task automatic do_write(input string tag, input logic [7:0] op,
                            input logic [31:0] adr, input logic [31:0] wd);
        int k;
        issue_cmd(tag, op, adr, wd);
        step(4);
        check({tag, "_hold"}, 72'(busy), 72'(1'b1));
        bus.rsp_tgl = ~bus.rsp_tgl;
        k = 0;
        do begin
            step(1);
            k++;
        end while (busy && k < 4);
        check({tag, "_done"}, 72'(busy), 72'(1'b0));
    endtask

    task automatic do_read(input string tag, input logic [31:0] adr,
                           input logic [31:0] rd, input int abort_at);
        logic [71:0] got;
        logic [71:0] exp;
        issue_cmd(tag, 8'h02, adr, 32'($urandom));
        bus.rdata   = rd;
        bus.rsp_tgl = ~bus.rsp_tgl;
        step(4);
        check({tag, "_armtx"}, 72'(busy), 72'(1'b1));
        step(int'($urandom_range(0, 3)));
        exp = {8'h0F, adr, rd};
        got = '0;
        cs  = 1'b0;
        step(1);
        for (int i = 0; i < 72; i++) begin
            if (abort_at > 0 && i == abort_at) begin
                cs = 1'b1;
                step(1);
                bump_err();
                check({tag, "_sabort"}, 72'(busy), 72'(1'b0));
                check({tag, "_sabort_err"}, 72'(err_cnt), 72'(m_err[7:0]));
                return;
            end
            got[71-i] = miso;
            mosi = 1'($urandom);
            step(1);
        end
        check({tag, "_miso"}, got, exp);
        check({tag, "_end"}, 72'({busy, miso}), 72'(2'b00));
        cs = 1'b1;
    endtask

    task automatic do_abort(input string tag, input int nbits);
        arm();
        drive_bits({$urandom, $urandom, 8'($urandom)}, nbits);
        cs = 1'b1;
        step(1);
        bump_err();
        check_regs(tag);
        check({tag, "_busy"}, 72'(busy), 72'(1'b0));
    endtask

    task automatic do_illegal(input string tag);
        logic [7:0] op;
        do op = 8'($urandom); while (op == 8'h01 || op == 8'h02 || op == 8'h03);
        arm();
        drive_bits({op, $urandom, $urandom}, 72);
        cs = 1'b1;
        step(2);
        bump_err();
        check_regs(tag);
        check({tag, "_busy"}, 72'(busy), 72'(1'b0));
    endtask

    initial begin
        bus.rsp_tgl = 1'b0;
        bus.rdata   = 32'd0;
        model_reset();

        // Reset state
        step(2);
        check_regs("rst");
        check("rst_busy_miso", 72'({busy, miso}), 72'(2'b00));

        // cs never high after reset: a full frame must be ignored
        rstn = 1'b1;
        drive_bits({8'h01, 32'h0000_0010, 32'hDEAD_BEEF}, 72);
        step(2);
        check_regs("noarm");
        check("noarm_busy", 72'(busy), 72'(1'b0));

        // Directed write, read, abort, illegal
        do_write("wr_dir", 8'h01, 32'h0000_0010, 32'hDEAD_BEEF);
        do_read("rd_dir", 32'h0000_0020, 32'h1234_5678, 0);
        do_abort("ab_dir", 40);
        do_write("wr_after_ab", 8'h01, 32'hCAFE_0004, 32'h0BAD_F00D);
        do_illegal("ill_dir");

        // Randomised transaction mix
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.rsp_tgl = ~bus.rsp_tgl;
                step(4);
            end
            case ($urandom_range(0, 4))
                0: do_write("wr_rnd", 8'h01, $urandom, $urandom);
                1: do_write("st_rnd", 8'h03, $urandom, $urandom);
                2: do_read("rd_rnd", $urandom, $urandom,
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 71)) : 0);
                3: do_abort("ab_rnd", int'($urandom_range(1, 71)));
                default: do_illegal("ill_rnd");
            endcase
        end

        // Back-to-back: 144 bits with cs held low, only the first is taken
        arm();
        drive_bits({8'h01, 32'h0000_0044, 32'h5555_AAAA}, 72);
        m_req = ~m_req; m_cmd = 2'b01; m_adr = 32'h0000_0044; m_wdata = 32'h5555_AAAA;
        drive_bits({8'h02, $urandom, $urandom}, 72);
        check_regs("b2b");
        check("b2b_busy", 72'(busy), 72'(1'b1));

        // Asynchronous reset during WAIT_RSP
        #2 rstn = 1'b0;
        bus.rsp_tgl = 1'b0;
        #1;
        model_reset();
        check_regs("arst");
        check("arst_busy_miso", 72'({busy, miso}), 72'(2'b00));
        step(2);
        rstn = 1'b1;

        // err_cnt saturation via short aborts
        cs = 1'b1;
        step(1);
        for (int i = 0; i < 260; i++) begin
            cs = 1'b0;
            step(1);
            cs = 1'b1;
            step(1);
            bump_err();
        end
        check("sat_err", 72'(err_cnt), 72'(m_err[7:0]));
        check("sat_busy", 72'(busy), 72'(1'b0));
        do_write("wr_post_sat", 8'h03, $urandom, $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 Parameter FRAME_BITS, default 72, is the number of bits in every SPI frame: 8-bit command, 32-bit address, 32-bit data, MSB first.
REQ-002 Parameter SYNC_STAGES, default 2, is the number of synchronizer flops on rsp_tgl.
REQ-003 sclk  input  1  clock; SPI clock, free-running, all state updates on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 cs  input  1  chip select, active-low; frame delimiter.
REQ-006 mosi  input  1  serial data in.
REQ-007 miso  output  1  serial data out.
REQ-008 req_tgl  output  1  toggles once per accepted command; crosses to the core clock domain.
REQ-009 cmd  output  2  latched command: 01 write, 10 read, 11 start.
REQ-010 adr  output  32  latched address.
REQ-011 wdata  output  32  latched write data.
REQ-012 rsp_tgl  input  1  toggled by the core domain when the command is complete.
REQ-013 rdata  input  32  read data; stable from the rsp_tgl toggle until the next req_tgl toggle.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err_cnt  output  8  saturating count of aborted or illegal frames.

Function
REQ-016 The FSM SHALL have the states IDLE, SHIFT, DECODE, WAIT_RSP, ARM_TX and SEND.
REQ-017 armed SHALL set on any sclk edge that samples cs=1 and SHALL clear when a frame starts.
REQ-018 IDLE: when cs=0 and armed=1, the block SHALL shift mosi into sr[0], set bitcnt=1 and go to SHIFT.
REQ-019 IDLE: when cs=0 and armed=0, the block SHALL ignore the edge.
REQ-020 SHIFT: on each edge with cs=0, the block SHALL do sr<={sr[70:0],mosi} and bitcnt++.
REQ-021 SHIFT: on the edge that captures bit FRAME_BITS (bitcnt 71->72), the FSM SHALL go to DECODE.
REQ-022 SHIFT: if cs=1 is sampled before 72 bits, the FSM SHALL go to IDLE, err_cnt++, with no request and sr contents discarded.
REQ-023 DECODE (one cycle): if sr[71:64] is 8'h01, 8'h02 or 8'h03, the block SHALL load cmd=sr[65:64], adr=sr[63:32] and wdata=sr[31:0] in the same edge, toggle req_tgl, and go to WAIT_RSP.
REQ-024 DECODE: for any other opcode, err_cnt++ and the FSM SHALL go to IDLE; req_tgl and the cmd/adr/wdata outputs SHALL be unchanged.
REQ-025 The rsp_tgl path SHALL be a SYNC_STAGES-flop synchronizer plus one edge-detect flop; rsp_evt = sync_out XOR edge_flop.
REQ-026 With setup met, rsp_evt SHALL first be high in the state evaluated at the (SYNC_STAGES+1)th sclk edge after the rsp_tgl change.
REQ-027 WAIT_RSP: on rsp_evt with cmd=10, sr SHALL load {8'h0F, adr, rdata} and the FSM SHALL go to ARM_TX.
REQ-028 WAIT_RSP: on rsp_evt with cmd=01 or 11, the FSM SHALL go to IDLE.
REQ-029 WAIT_RSP and DECODE SHALL ignore cs and mosi.
REQ-030 ARM_TX: the FSM SHALL wait for armed=1 and then cs=0, then enter SEND on that edge with bitcnt=0 and no shift.
REQ-031 SEND: miso SHALL equal sr[71] combinationally; in every other state miso SHALL be 0.
REQ-032 SEND: each edge with cs=0 SHALL do sr<={sr[70:0],1'b0} and bitcnt++; mosi is ignored.
REQ-033 SEND: after 72 shifts, the FSM SHALL go to IDLE.
REQ-034 SEND: cs=1 sampled before 72 shifts SHALL send the FSM to IDLE with err_cnt++.
REQ-035 bitcnt SHALL be 7 bits and never exceed 72.
REQ-036 err_cnt SHALL saturate at 8'hFF.
REQ-037 An unexpected rsp_evt in IDLE, SHIFT, ARM_TX or SEND SHALL be ignored and consumed, with the edge flop updated.
REQ-038 A new frame SHALL be accepted only in IDLE; there is no command queueing.

Reset
REQ-039 While rstn=0, the block SHALL force state=IDLE, sr=0, bitcnt=0, armed=0, req_tgl=0, cmd=0, adr=0, wdata=0, err_cnt=0, all synchronizer and edge flops=0, miso=0 and busy=0.
REQ-040 A reset mid-frame or mid-handshake SHALL abandon the operation silently; the core domain resets req/rsp toggles together with this block.
REQ-041 After reset release, no frame SHALL be accepted until cs=1 has been sampled at least once.

Verification
REQ-042 Write frame: cs high 2 edges, then cs low for 72 bits of 0x01_00000010_DEADBEEF -> one req_tgl toggle, cmd=01, adr=0x10, wdata=0xDEADBEEF; toggle rsp_tgl -> IDLE and busy=0 within 4 edges.
REQ-043 Read frame: frame 0x02_00000020_xxxxxxxx; rdata=0x12345678, rsp_tgl toggled; then cs high/low for 72 clocks -> miso emits 0x0F_00000020_12345678 MSB first, then IDLE.
REQ-044 Abort: cs raised after 40 bits -> no req_tgl change, err_cnt=1, next complete frame accepted normally.
REQ-045 Illegal opcode 0x07 -> err_cnt increments, req_tgl unchanged, state IDLE.
REQ-046 Back-to-back: cs held low for 144 bits -> only the first frame is accepted, busy=1, and the second 72 bits are ignored; rstn pulsed low during WAIT_RSP -> all outputs at their REQ-039 reset values.
